// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte output, frame/overrun pulses and stretched activity LED
module uart_rx #(
    parameter int CLKS_PER_BIT = 417,
    parameter int ACT_CLKS = 2400000
) (
    input  logic       ref_clk,
    input  logic       reset_inv,
    input  logic       io_0,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       led_act
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(ACT_CLKS);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t state;
    logic s1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic [AW-1:0] act_cnt;
    logic bit_end;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign led_act = rx_s && (act_cnt == '0);
    always_ff @(posedge ref_clk or negedge reset_inv) begin
        if (!reset_inv) begin
            s1 <= 1'b1;
            rx_s <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            act_cnt <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            {rx_s, s1} <= {s1, io_0};
            frame_err <= 1'b0;
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (act_cnt != '0) act_cnt <= act_cnt - 1'b1;
            case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt <= '0;
                end
                START: if (cnt == CW'(HALF - 1)) begin
                    cnt <= '0;
                    bit_idx <= '0;
                    if (rx_s) state <= IDLE;
                    else begin
                        state <= DATA;
                        act_cnt <= AW'(ACT_CLKS - 1);
                    end
                end else cnt <= cnt + 1'b1;
                DATA: if (bit_end) begin
                    cnt <= '0;
                    shift[bit_idx] <= rx_s;
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (bit_end) begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        // a delivery coinciding with acceptance overrides the handshake clear above
                        if (!rx_valid || rx_ready) begin
                            rx_data <= shift;
                            rx_valid <= 1'b1;
                        end else overrun <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                        state <= BREAK;
                    end
                end else cnt <= cnt + 1'b1;
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx with CLKS_PER_BIT=8, ACT_CLKS=32
module tb_uart_rx;
    localparam int CPB = 8;
    localparam int ACT = 32;
    logic ref_clk = 1'b0, reset_inv = 1'b0, io_0 = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic rx_valid, frame_err, overrun, led_act;
    int passed = 0, total = 0, cyc = 0;
    int vcyc, ferr_n, ovr_n, both_n, led_low_n, first_v, t0;
    logic [7:0] got[$];
    typedef struct {
        logic [7:0] tx;
        logic       stop;
        int         exp_push;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[6];

    uart_rx #(.CLKS_PER_BIT(CPB), .ACT_CLKS(ACT)) dut (
        .ref_clk(ref_clk), .reset_inv(reset_inv), .io_0(io_0),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .led_act(led_act)
    );

    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    always @(negedge ref_clk) if (reset_inv) begin
        if (rx_valid) vcyc++;
        if (rx_valid && first_v < 0) first_v = cyc;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) ferr_n++;
        if (overrun) ovr_n++;
        if (frame_err && overrun) both_n++;
        if (!led_act) led_low_n++;
    end

    task automatic clr();
        vcyc = 0; ferr_n = 0; ovr_n = 0; led_low_n = 0; first_v = -1;
        got.delete();
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic drive_bit(logic b);
        io_0 = b;
        tick(CPB);
    endtask

    task automatic send(logic [7:0] d, logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    initial begin
        both_n = 0;
        clr();
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h55, 1'b1, 1, 8'h55, 0};
        vecs[4] = '{8'h81, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h42, 1'b1, 1, 8'h42, 0};
        tick(3);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_led", led_act, 1'b1);
        reset_inv = 1'b1;
        rx_ready = 1'b1;
        tick(5);
        for (int i = 0; i < 6; i++) begin
            clr();
            t0 = cyc;
            send(vecs[i].tx, vecs[i].stop);
            io_0 = 1'b1;
            tick(4);
            check($sformatf("v%0d_valid_cycles", i), vcyc, vecs[i].exp_push);
            check($sformatf("v%0d_pushes", i), got.size(), vecs[i].exp_push);
            if (vecs[i].exp_push == 1 && got.size() == 1)
                check($sformatf("v%0d_data", i), got[0], vecs[i].exp_data);
            check($sformatf("v%0d_ferr", i), ferr_n, vecs[i].exp_ferr);
            check($sformatf("v%0d_ovr", i), ovr_n, 0);
            // 2 sync flops + IDLE detect edge (3) + HALF (4) + 9 bit periods (72)
            if (i == 0) check("a5_valid_latency", first_v - t0, 79);
        end
        clr();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        tick(4);
        check("b2b_count", got.size(), 3);
        if (got.size() == 3) begin
            check("b2b_0", got[0], 8'h00);
            check("b2b_1", got[1], 8'hFF);
            check("b2b_2", got[2], 8'h55);
        end
        check("b2b_ferr", ferr_n, 0);
        rx_ready = 1'b0;
        clr();
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        tick(4);
        check("ovr_valid_held", rx_valid, 1'b1);
        check("ovr_data_held", rx_data, 8'h3C);
        check("ovr_pulses", ovr_n, 1);
        rx_ready = 1'b1;
        @(posedge ref_clk);
        @(negedge ref_clk);
        check("ovr_valid_drop", rx_valid, 1'b0);
        check("ovr_accepted", got.size(), 1);
        if (got.size() == 1) check("ovr_accepted_data", got[0], 8'h3C);
        tick(10);
        clr();
        send(8'h81, 1'b0);
        tick(40);
        check("brk_ferr", ferr_n, 1);
        check("brk_no_valid", vcyc, 0);
        check("brk_state", int'(dut.state), 4);
        io_0 = 1'b1;
        tick(10);
        check("brk_exit_idle", int'(dut.state), 0);
        clr();
        send(8'h42, 1'b1);
        tick(4);
        check("brk_after_count", got.size(), 1);
        if (got.size() == 1) check("brk_after_data", got[0], 8'h42);
        tick(60);
        check("led_idle_off", led_act, 1'b1);
        clr();
        io_0 = 1'b0;
        tick(2);
        io_0 = 1'b1;
        tick(20);
        check("glitch_valid", vcyc, 0);
        check("glitch_ferr", ferr_n, 0);
        check("glitch_idle", int'(dut.state), 0);
        check("glitch_led_low", led_low_n, 2);
        check("glitch_no_stretch", dut.act_cnt, 0);
        clr();
        io_0 = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b0 : 1'b1);
        io_0 = 1'b1;
        tick(CPB / 2);
        reset_inv = 1'b0;
        #2;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_led", led_act, 1'b1);
        io_0 = 1'b1;
        tick(3);
        reset_inv = 1'b1;
        tick(100);
        check("abort_no_valid", vcyc, 0);
        check("abort_no_ferr", ferr_n, 0);
        send(8'h7E, 1'b1);
        tick(4);
        check("after_rst_count", got.size(), 1);
        if (got.size() == 1) check("after_rst_data", got[0], 8'h7E);
        check("never_both", both_n, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that consumes the Feather RX pin (io_0, idle high) on the OrangeCrab 85F board.
- Sits directly downstream of the board's RX pin and delivers each received byte over a valid/ready interface to later logic.
- Also drives an active-low activity LED, a stretched replacement for the raw RX-follows-LED hookup.

Parameters:
- CLKS_PER_BIT, 417, ref_clk cycles per bit (48 MHz / 115200 rounded); must be >= 4 and even-safe (HALF = CLKS_PER_BIT/2, integer floor)
- ACT_CLKS, 2400000, led_act stretch length in clocks after each start bit (50 ms)

Ports:
- ref_clk  input  1  48 MHz clock; all logic on rising edge
- reset_inv  input  1  asynchronous, active-low reset
- io_0  input  1  raw RX pin, asynchronous, idle high
- rx_data  output  8  received byte, LSB first on wire; stable while rx_valid=1
- rx_valid  output  1  byte available
- rx_ready  input  1  consumer accepts byte when rx_valid&rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: new byte dropped because previous byte unconsumed
- led_act  output  1  activity LED, active low

Behaviour:
- Reset (reset_inv=0, async):
  - 2-flop synchronizer preset to 1; state=IDLE; counters=0.
  - Outputs: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, led_act=1 (off).
  - Reset mid-frame abandons the frame; no pulse is emitted.
- Synchronizer: rx_s = io_0 after 2 flops. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on rx_s==0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt==HALF-1, sample rx_s:
    - 0: go to DATA with cnt=0, bit index=0.
    - 1: glitch; return to IDLE with no output.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit], clear cnt and increment bit. After bit 7 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
    - 1: deliver byte, go to IDLE (next start is detectable from the following cycle).
    - 0: frame_err=1 for one cycle, byte discarded, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. Handles line-low/break conditions without spurious frames.
- Sample timing: with T = the cycle IDLE first sees rx_s==0, bit k (start=0, data 1..8, stop=9) is sampled at cycle T+HALF+k*CLKS_PER_BIT.
- Delivery (registered; effective the cycle after the stop sample):
  - rx_valid=0, or rx_valid&rx_ready in the delivery cycle: rx_data<=shift, rx_valid<=1.
  - rx_valid=1 and rx_ready=0: byte dropped, overrun=1 for one cycle, rx_data/rx_valid unchanged.
- Handshake:
  - rx_valid, once set, stays 1 with rx_data held until rx_valid&rx_ready.
  - The cycle after acceptance, rx_valid=0, unless a new delivery coincided with acceptance, in which case rx_valid stays 1 with the new data.
  - rx_ready while rx_valid=0 has no effect.
- Activity LED:
  - led_act=0 while rx_s==0, or while the stretch counter is nonzero.
  - The stretch counter loads ACT_CLKS-1 on each START→DATA transition and decrements to 0.
  - Width is clog2(ACT_CLKS).
- frame_err and overrun are never both 1 in one cycle.

Test Plan:
- CLKS_PER_BIT=8, ACT_CLKS=32. Send 8'hA5 8N1 with rx_ready held 1 → rx_valid pulses exactly one cycle with rx_data=8'hA5; the pulse occurs at T+4+72+1; frame_err=0, overrun=0.
- rx_ready=0, send 8'h3C then 8'hC3 → rx_data stays 8'h3C with rx_valid=1. At the second stop, overrun pulses one cycle. Raise rx_ready → rx_valid drops next cycle; 8'hC3 is never seen.
- Back-to-back 8'h00, 8'hFF, 8'h55 with a start immediately after each stop, rx_ready=1 → three deliveries in order, no errors.
- Stop bit forced low on 8'h81, line then held low 40 clocks → one frame_err pulse, no rx_valid, FSM in BREAK. Line returns high, then 8'h42 is sent → 8'h42 delivered.
- 2-clock low glitch on io_0 while idle → no rx_valid, no frame_err, FSM back in IDLE. led_act=0 only during the glitch (+ sync delay); the stretch counter is not loaded.
- Assert reset_inv=0 in the middle of data bit 4, release, then send 8'h7E → no output from the aborted frame. All outputs read reset values during reset. 8'h7E is delivered correctly.
